// File: rtl/types_def.sv
// Shared request types for the bank dispatcher.
//   r_type     : request direction (read / write)
//   bank_req_t : one queued bank entry {t, ra, ca, dq, idx}
// The struct field widths are the default geometry.
// bank_dispatcher instances must use these CA/RA/DQ/IDX values.
package types_def;

    localparam int unsigned CA_W  = 10;
    localparam int unsigned RA_W  = 16;
    localparam int unsigned DQ_W  = 16;
    localparam int unsigned IDX_W = 7;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } r_type;

    typedef struct packed {
        r_type             t;
        logic [RA_W-1:0]   ra;
        logic [CA_W-1:0]   ca;
        logic [DQ_W-1:0]   dq;
        logic [IDX_W-1:0]  idx;
    } bank_req_t;

endpackage

// File: rtl/bank_fifo.sv
// Single-clock FIFO that holds the queue for one bank.
//   clk, rst    : clock and synchronous active-high reset (pointers only)
//   push, din   : write port; a push is ignored when full
//   pop, dout   : read port; dout shows the head entry; a pop is ignored when empty
//   full, empty : derived from the pointers
// Each pointer has one extra wrap bit. The pointers count modulo 2*DEPTH.
// The FIFO is full when the index bits match and the wrap bits differ.
// A pushed entry appears on dout in the next cycle. There is no bypass path.
module bank_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset. Only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bank_dispatcher.sv
// Routes host requests into per-bank queues and tracks completion tags.
//   clk, rst                        : clock and synchronous active-high reset
//   in_valid/in_type/in_addr/in_data: host request
//   in_ready                        : the request is taken when in_valid is also high
//   valid_o/t_o/ra_o/ca_o/dq_o/idx_o: head entry of each bank queue
//   ready_i                         : per-bank pop from the scheduler
//   done_valid/done_idx/done_data   : completion from the back end
//   resp_*                          : registered completion to the host
//   outstanding                     : number of busy tags (maximum 2^IDX)
//   err_o                           : sticky flag; set by a completion on a free tag
module bank_dispatcher
    import types_def::*;
#(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CA        = CA_W,
    parameter int unsigned RA        = RA_W,
    parameter int unsigned DQ        = DQ_W,
    parameter int unsigned IDX       = IDX_W,
    localparam int unsigned BW       = $clog2(NUM_BANKS),
    localparam int unsigned ADDR_W   = CA + BW + RA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  r_type                in_type,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DQ-1:0]        in_data,
    output logic                 in_ready,
    output logic [NUM_BANKS-1:0] valid_o,
    output r_type                t_o   [NUM_BANKS],
    output logic [RA-1:0]        ra_o  [NUM_BANKS],
    output logic [CA-1:0]        ca_o  [NUM_BANKS],
    output logic [DQ-1:0]        dq_o  [NUM_BANKS],
    output logic [IDX-1:0]       idx_o [NUM_BANKS],
    input  logic [NUM_BANKS-1:0] ready_i,
    input  logic                 done_valid,
    input  logic [IDX-1:0]       done_idx,
    input  logic [DQ-1:0]        done_data,
    output logic                 resp_valid,
    output logic [IDX-1:0]       resp_idx,
    output r_type                resp_type,
    output logic [DQ-1:0]        resp_data,
    output logic [IDX:0]         outstanding,
    output logic                 err_o
);

    localparam int unsigned NUM_TAGS = 1 << IDX;

    logic [CA-1:0]        req_ca;
    logic [BW-1:0]        req_bank;
    logic [RA-1:0]        req_ra;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] empty;
    logic [NUM_TAGS-1:0]  busy;
    r_type                type_mem [NUM_TAGS];
    logic                 any_free;
    logic [IDX-1:0]       free_idx;
    logic                 accept;
    logic                 done_ok;
    logic                 done_bad;
    bank_req_t            req_entry;
    bank_req_t            head [NUM_BANKS];

    assign req_ca   = in_addr[CA-1:0];
    assign req_bank = in_addr[CA +: BW];
    assign req_ra   = in_addr[CA+BW +: RA];

    // Priority encoder that picks the lowest free tag.
    // It reads the registered bitmap, so a tag freed in this cycle is not
    // handed out until the next cycle.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!busy[i] && !any_free) begin
                any_free = 1'b1;
                free_idx = IDX'(i);
            end
        end
    end

    assign in_ready = !rst && !full[req_bank] && any_free;
    assign accept   = in_valid && in_ready;
    assign done_ok  = done_valid && busy[done_idx];
    assign done_bad = done_valid && !busy[done_idx];

    assign req_entry = '{t: in_type, ra: req_ra, ca: req_ca, dq: in_data, idx: free_idx};

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_fifo #(
            .WIDTH ($bits(bank_req_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (accept && (req_bank == BW'(g))),
            .din   (req_entry),
            .pop   (valid_o[g] && ready_i[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );

        assign valid_o[g] = !empty[g];
        assign t_o[g]     = head[g].t;
        assign ra_o[g]    = head[g].ra;
        assign ca_o[g]    = head[g].ca;
        assign dq_o[g]    = head[g].dq;
        assign idx_o[g]   = head[g].idx;
    end

    // The tag being allocated is free and the tag being completed is busy.
    // The two bitmap writes can never hit the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
            err_o       <= 1'b0;
            resp_valid  <= 1'b0;
        end else begin
            if (accept)
                busy[free_idx] <= 1'b1;
            if (done_ok)
                busy[done_idx] <= 1'b0;
            resp_valid <= done_ok;
            if (done_bad)
                err_o <= 1'b1;
            case ({accept, done_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            type_mem[free_idx] <= in_type;
        if (done_ok) begin
            resp_idx  <= done_idx;
            resp_data <= done_data;
            resp_type <= type_mem[done_idx];
        end
    end

endmodule

// File: tb/tb_bank_dispatcher.sv
// Directed self-checking bench for bank_dispatcher with the default geometry.
module tb_bank_dispatcher;
    import types_def::*;

    localparam int unsigned NB  = 16;
    localparam int unsigned DEP = 4;
    localparam int unsigned CAW = 10;
    localparam int unsigned RAW = 16;
    localparam int unsigned DQW = 16;
    localparam int unsigned IW  = 7;
    localparam int unsigned BWW = 4;
    localparam int unsigned AW  = CAW + BWW + RAW;

    logic           clk;
    logic           rst;
    logic           in_valid;
    r_type          in_type;
    logic [AW-1:0]  in_addr;
    logic [DQW-1:0] in_data;
    logic           in_ready;
    logic [NB-1:0]  valid_o;
    r_type          t_o   [NB];
    logic [RAW-1:0] ra_o  [NB];
    logic [CAW-1:0] ca_o  [NB];
    logic [DQW-1:0] dq_o  [NB];
    logic [IW-1:0]  idx_o [NB];
    logic [NB-1:0]  ready_i;
    logic           done_valid;
    logic [IW-1:0]  done_idx;
    logic [DQW-1:0] done_data;
    logic           resp_valid;
    logic [IW-1:0]  resp_idx;
    r_type          resp_type;
    logic [DQW-1:0] resp_data;
    logic [IW:0]    outstanding;
    logic           err_o;

    int n_checks = 0;
    int n_fail   = 0;

    bank_dispatcher #(
        .NUM_BANKS (NB),
        .DEPTH     (DEP),
        .CA        (CAW),
        .RA        (RAW),
        .DQ        (DQW),
        .IDX       (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_type     (in_type),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .valid_o     (valid_o),
        .t_o         (t_o),
        .ra_o        (ra_o),
        .ca_o        (ca_o),
        .dq_o        (dq_o),
        .idx_o       (idx_o),
        .ready_i     (ready_i),
        .done_valid  (done_valid),
        .done_idx    (done_idx),
        .done_data   (done_data),
        .resp_valid  (resp_valid),
        .resp_idx    (resp_idx),
        .resp_type   (resp_type),
        .resp_data   (resp_data),
        .outstanding (outstanding),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] mk_addr(input int unsigned bank, input int unsigned ra,
                                              input int unsigned ca);
        return {RAW'(ra), BWW'(bank), CAW'(ca)};
    endfunction

    task automatic send(input logic [AW-1:0] a, input logic [DQW-1:0] d, input r_type t);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_type  = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic complete(input logic [IW-1:0] idx, input logic [DQW-1:0] d);
        @(negedge clk);
        done_valid = 1'b1;
        done_idx   = idx;
        done_data  = d;
        @(posedge clk);
        #1;
        done_valid = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_type    = WRITE;
        in_addr    = mk_addr(2, 0, 0);
        in_data    = '0;
        ready_i    = '0;
        done_valid = 1'b0;
        done_idx   = '0;
        done_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready); end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== '0) begin n_fail++; $display("FAIL reset_valid_o: got %h expected 0", valid_o); end
        n_checks++;
        if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        n_checks++;
        if (err_o !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_err_resp: got err=%b resp=%b expected 0 0", err_o, resp_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_write;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 30'h0000_0400;
        in_data  = 16'hBEEF;
        in_type  = WRITE;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (valid_o[1] !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", valid_o[1]); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (valid_o[1] !== 1'b1 || idx_o[1] !== 7'd0 || ca_o[1] !== 10'd0 || ra_o[1] !== 16'd0)
            begin n_fail++; $display("FAIL single_head: got v=%b idx=%0d ca=%0d ra=%0d expected 1 0 0 0", valid_o[1], idx_o[1], ca_o[1], ra_o[1]); end
        n_checks++;
        if (dq_o[1] !== 16'hBEEF || t_o[1] !== WRITE) begin n_fail++; $display("FAIL single_payload: got dq=%h t=%b expected beef 1", dq_o[1], t_o[1]); end
        n_checks++;
        if (outstanding !== 8'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
        ready_i[1] = 1'b1;
        @(posedge clk);
        #1;
        ready_i[1] = 1'b0;
        n_checks++;
        if (valid_o[1] !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b expected 0", valid_o[1]); end
        complete(7'd0, 16'h5A5A);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_idx !== 7'd0 || resp_type !== WRITE || resp_data !== 16'h5A5A)
            begin n_fail++; $display("FAIL single_resp: got v=%b idx=%0d t=%b d=%h expected 1 0 1 5a5a", resp_valid, resp_idx, resp_type, resp_data); end
        n_checks++;
        if (outstanding !== 8'd0) begin n_fail++; $display("FAIL single_outstanding_done: got %0d expected 0", outstanding); end
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_resp_one_cycle: got %b expected 0", resp_valid); end
    endtask

    task automatic test_fifo_full;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = mk_addr(3, i, i + 1);
            in_data  = 16'(i);
            in_type  = WRITE;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_accept_%0d: got %b expected 1", i, in_ready); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_addr = mk_addr(3, 4, 5);
        in_data = 16'd4;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_block: got %b expected 0", in_ready); end
        n_checks++;
        if (valid_o[3] !== 1'b1 || idx_o[3] !== 7'd0 || outstanding !== 8'd4)
            begin n_fail++; $display("FAIL fifo_full_state: got v=%b idx=%0d out=%0d expected 1 0 4", valid_o[3], idx_o[3], outstanding); end
        ready_i[3] = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_pop_no_pass: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        ready_i[3] = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_after_pop_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (outstanding !== 8'd5) begin n_fail++; $display("FAIL fifo_fifth_accepted: got %0d expected 5", outstanding); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (valid_o[3] !== 1'b1 || idx_o[3] !== IW'(k) || ca_o[3] !== CAW'(k + 1) || dq_o[3] !== DQW'(k))
                begin n_fail++; $display("FAIL fifo_order_%0d: got v=%b idx=%0d ca=%0d dq=%0d expected 1 %0d %0d %0d", k, valid_o[3], idx_o[3], ca_o[3], dq_o[3], k, k + 1, k); end
            ready_i[3] = 1'b1;
            @(posedge clk);
            #1;
            ready_i[3] = 1'b0;
        end
        n_checks++;
        if (valid_o[3] !== 1'b0) begin n_fail++; $display("FAIL fifo_drained: got %b expected 0", valid_o[3]); end
        for (int k = 0; k < 5; k++) begin
            complete(IW'(k), DQW'(k));
            n_checks++;
            if (resp_valid !== 1'b1 || resp_idx !== IW'(k)) begin n_fail++; $display("FAIL fifo_free_%0d: got v=%b idx=%0d expected 1 %0d", k, resp_valid, resp_idx, k); end
        end
        n_checks++;
        if (outstanding !== 8'd0) begin n_fail++; $display("FAIL fifo_outstanding_end: got %0d expected 0", outstanding); end
    endtask

    task automatic test_read_completion;
        send(mk_addr(2, 1, 1), 16'h000A, WRITE);
        send(mk_addr(2, 2, 2), 16'h000B, WRITE);
        send(mk_addr(2, 3, 3), 16'h000C, READ);
        n_checks++;
        if (outstanding !== 8'd3) begin n_fail++; $display("FAIL read_outstanding_3: got %0d expected 3", outstanding); end
        @(negedge clk);
        in_valid   = 1'b1;
        in_addr    = mk_addr(5, 0, 7);
        in_data    = 16'h0077;
        in_type    = WRITE;
        done_valid = 1'b1;
        done_idx   = 7'd2;
        done_data  = 16'h1234;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        done_valid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_idx !== 7'd2 || resp_type !== READ || resp_data !== 16'h1234)
            begin n_fail++; $display("FAIL read_resp: got v=%b idx=%0d t=%b d=%h expected 1 2 0 1234", resp_valid, resp_idx, resp_type, resp_data); end
        n_checks++;
        if (outstanding !== 8'd3) begin n_fail++; $display("FAIL read_outstanding_hold: got %0d expected 3", outstanding); end
        n_checks++;
        if (idx_o[5] !== 7'd3) begin n_fail++; $display("FAIL read_no_same_cycle_reuse: got %0d expected 3", idx_o[5]); end
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL read_resp_one_cycle: got %b expected 0", resp_valid); end
        complete(7'd0, 16'h0000);
        n_checks++;
        if (outstanding !== 8'd2) begin n_fail++; $display("FAIL read_outstanding_dec: got %0d expected 2", outstanding); end
    endtask

    task automatic test_error;
        complete(7'd9, 16'hDEAD);
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_resp: got %b expected 0", resp_valid); end
        n_checks++;
        if (err_o !== 1'b1 || outstanding !== 8'd2) begin n_fail++; $display("FAIL err_set: got err=%b out=%0d expected 1 2", err_o, outstanding); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    endtask

    task automatic test_outstanding_full;
        int rejected;
        rejected = 0;
        do_reset();
        n_checks++;
        if (err_o !== 1'b0 || outstanding !== 8'd0) begin n_fail++; $display("FAIL full_reset: got err=%b out=%0d expected 0 0", err_o, outstanding); end
        ready_i = '1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = mk_addr(i % 16, i, 0);
            in_data  = 16'(i);
            in_type  = WRITE;
            #1;
            if (!in_ready) rejected++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rejected !== 0) begin n_fail++; $display("FAIL full_all_accepted: got %0d rejects expected 0", rejected); end
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = mk_addr(0, 1, 1);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || outstanding !== 8'd128) begin n_fail++; $display("FAIL full_tags_exhausted: got rdy=%b out=%0d expected 0 128", in_ready, outstanding); end
        @(posedge clk);
        #1;
        ready_i = '0;
        @(negedge clk);
        done_valid = 1'b1;
        done_idx   = 7'd5;
        done_data  = 16'h0055;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_block: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        done_valid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_idx !== 7'd5 || outstanding !== 8'd127)
            begin n_fail++; $display("FAIL full_done5: got v=%b idx=%0d out=%0d expected 1 5 127", resp_valid, resp_idx, outstanding); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_free: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (valid_o[0] !== 1'b1 || idx_o[0] !== 7'd5 || outstanding !== 8'd128 || resp_valid !== 1'b0)
            begin n_fail++; $display("FAIL full_realloc5: got v=%b idx=%0d out=%0d resp=%b expected 1 5 128 0", valid_o[0], idx_o[0], outstanding, resp_valid); end
    endtask

    task automatic test_reset_midop;
        do_reset();
        ready_i = '0;
        for (int i = 0; i < 3; i++) send(mk_addr(0, i, i), 16'(i), WRITE);
        n_checks++;
        if (valid_o[0] !== 1'b1 || outstanding !== 8'd3) begin n_fail++; $display("FAIL midop_queued: got v=%b out=%0d expected 1 3", valid_o[0], outstanding); end
        @(negedge clk);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_addr    = mk_addr(4, 0, 0);
        done_valid = 1'b1;
        done_idx   = 7'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midop_ready_in_rst: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        done_valid = 1'b0;
        n_checks++;
        if (valid_o !== '0 || outstanding !== 8'd0 || resp_valid !== 1'b0)
            begin n_fail++; $display("FAIL midop_cleared: got v=%h out=%0d resp=%b expected 0 0 0", valid_o, outstanding, resp_valid); end
        send(mk_addr(0, 9, 9), 16'h0099, READ);
        n_checks++;
        if (valid_o[0] !== 1'b1 || idx_o[0] !== 7'd0 || ra_o[0] !== 16'd9 || t_o[0] !== READ)
            begin n_fail++; $display("FAIL midop_first_after: got v=%b idx=%0d ra=%0d t=%b expected 1 0 9 0", valid_o[0], idx_o[0], ra_o[0], t_o[0]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_fifo_full();
        test_read_completion();
        test_error();
        test_outstanding_full();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
